// File: rtl/fir_preadd_seq.sv
// Delay line and pair sequencer that drives an external symmetric-FIR pre-adder slice.
// Optional FIR_FLUSH_EN adds a 'flush' input that clears the delay line while idle.
module fir_preadd_seq #(
   parameter int              TAPS    = 8,
   parameter int              PA_LAT  = 3,
   parameter logic [TAPS-1:0] COEF_SH = 8'b11_10_01_00
) (
   input  logic        clk,
   input  logic        rst,
`ifdef FIR_FLUSH_EN
   input  logic        flush,
`endif
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_data,
   output logic [7:0]  x1,
   output logic [7:0]  x2,
   output logic [1:0]  h,
   output logic [11:0] carry,
   output logic        pa_clr,
   output logic        pa_en,
   input  logic [11:0] pa_result,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [11:0] y
);

   localparam int P  = TAPS / 2;
   localparam int KW = (P > 1) ? $clog2(P) : 1;
   localparam int CW = (PA_LAT > 1) ? $clog2(PA_LAT) : 1;

   typedef enum logic [2:0] {IDLE, CLR, EN, CAP, DONE} state_t;

   state_t          state_reg, state_next;
   logic [KW-1:0]   k_reg, k_next, k_inc;
   logic [CW-1:0]   cnt_reg, cnt_next;
   logic [7:0]      x1_reg, x1_next;
   logic [7:0]      x2_reg, x2_next;
   logic [1:0]      h_reg, h_next;
   logic [11:0]     carry_reg, carry_next;
   logic [7:0]      d_reg [TAPS];
   logic [7:0]      d_next [TAPS];
   logic [7:0]      pair_lo [P];
   logic [7:0]      pair_hi [P];
   logic [1:0]      h_tab [P];
   logic            accept;
   logic            clear_line;
   logic            flush_act;

`ifdef FIR_FLUSH_EN
   assign flush_act = flush;
`else
   assign flush_act = 1'b0;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < TAPS; gi++) begin : g_dly
         if (gi == 0) begin : g_head
            assign d_next[gi] = clear_line ? '0 : (accept ? in_data : d_reg[gi]);
         end else begin : g_tail
            assign d_next[gi] = clear_line ? '0 : (accept ? d_reg[gi-1] : d_reg[gi]);
         end
      end
      // Folded view of the line: pair k pairs the k-th newest with the k-th oldest sample.
      for (gi = 0; gi < P; gi++) begin : g_pair
         assign pair_lo[gi] = d_reg[gi];
         assign pair_hi[gi] = d_reg[TAPS-1-gi];
         assign h_tab[gi]   = COEF_SH[2*gi +: 2];
      end
   endgenerate

   assign k_inc = k_reg + KW'(1);

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      cnt_next   = cnt_reg;
      x1_next    = x1_reg;
      x2_next    = x2_reg;
      h_next     = h_reg;
      carry_next = carry_reg;
      in_ready   = 1'b0;
      pa_clr     = 1'b0;
      pa_en      = 1'b0;
      out_valid  = 1'b0;
      accept     = 1'b0;
      clear_line = 1'b0;
      case (state_reg)
         IDLE: begin
            in_ready = !flush_act;
            if (flush_act) begin
               clear_line = 1'b1;
            end else if (in_valid) begin
               // Operands for pair 0 come from the post-shift line.
               accept     = 1'b1;
               k_next     = '0;
               carry_next = '0;
               x1_next    = in_data;
               x2_next    = d_reg[TAPS-2];
               h_next     = h_tab[0];
               state_next = CLR;
            end
         end
         CLR: begin
            pa_clr     = 1'b1;
            cnt_next   = '0;
            state_next = EN;
         end
         EN: begin
            pa_en = 1'b1;
            if (cnt_reg == CW'(PA_LAT-1)) begin
               state_next = CAP;
            end else begin
               cnt_next = cnt_reg + CW'(1);
            end
         end
         CAP: begin
            carry_next = pa_result;
            if (k_reg == KW'(P-1)) begin
               state_next = DONE;
            end else begin
               k_next     = k_inc;
               x1_next    = pair_lo[k_inc];
               x2_next    = pair_hi[k_inc];
               h_next     = h_tab[k_inc];
               state_next = CLR;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         k_reg     <= '0;
         cnt_reg   <= '0;
         x1_reg    <= '0;
         x2_reg    <= '0;
         h_reg     <= '0;
         carry_reg <= '0;
         for (int i = 0; i < TAPS; i++) begin
            d_reg[i] <= '0;
         end
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
         cnt_reg   <= cnt_next;
         x1_reg    <= x1_next;
         x2_reg    <= x2_next;
         h_reg     <= h_next;
         carry_reg <= carry_next;
         d_reg     <= d_next;
      end
   end

   // The final captured carry is the filter output; it only changes on the next acceptance.
   assign y     = carry_reg;
   assign x1    = x1_reg;
   assign x2    = x2_reg;
   assign h     = h_reg;
   assign carry = carry_reg;

endmodule

// File: doc/fir_preadd_seq.md
# fir_preadd_seq

Sequencer and sample delay line that drives the symmetric-FIR pre-adder DSP slice from the opposite side of its interface. It accepts input samples over a valid/ready handshake and keeps a TAPS-deep delay line. For each symmetric tap pair it presents the two samples, the coefficient shift and the running carry to the pre-adder, then captures the pre-adder result as the next carry. After the last pair it emits the filter output over a valid/ready handshake.

## Interface
Parameters:
- TAPS, 8, filter length; even, ≥2; pair count P = TAPS/2
- PA_LAT, 3, cycles pa_en is held per pair (pre-adder stage count)
- COEF_SH, 8'b11_10_01_00, packed 2-bit shift per pair; pair k uses bits [2k+1:2k]

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-low; single clock domain
- in_valid  in  1  input sample valid
- in_ready  out  1  high only in IDLE
- in_data  in  8  input sample, unsigned
- x1  out  8  pre-adder operand d[k]
- x2  out  8  pre-adder operand d[TAPS-1-k]
- h  out  2  shift for pair k
- carry  out  12  running sum into pre-adder
- pa_clr  out  1  one-cycle pulse; restarts pre-adder stage sequence
- pa_en  out  1  pre-adder stage enable
- pa_result  in  12  pre-adder output, sampled in CAP
- out_valid  out  1  output valid
- out_ready  in  1  output accept
- y  out  12  filter output

## Operation
- Delay line d[0..TAPS-1], 8 b each; d[0] is the newest sample.
- FSM states: IDLE, CLR, EN, CAP, DONE.
- IDLE
  - in_ready=1.
  - On in_valid: d shifts (d[0]←in_data, d[i]←d[i-1]), k←0, carry←0, go to CLR.
- CLR: pa_clr=1 for one cycle, then EN.
- EN: pa_en=1 for exactly PA_LAT cycles (internal counter), then CAP.
- CAP: carry←pa_result.
  - If k==P-1, go to DONE.
  - Else k←k+1 and go to CLR.
- DONE
  - out_valid=1; y=carry, held stable.
  - On out_ready go to IDLE.
  - in_ready=0, so a new sample is never accepted while an output is pending.
- x1, x2, h and carry are registered and update in the same edge k changes. They are stable through CLR, EN and CAP of pair k.
- Arithmetic is done by the pre-adder: per pair carry_k+1 = carry_k + ((x1+x2)<<h). All values are 12-bit with silent wrap mod 4096; no saturation.
- Reset (rst=0 at an edge), in any state including mid-pair:
  - state←IDLE; d[], k, carry, y, x1, x2, h ← 0.
  - pa_en=pa_clr=out_valid=0.
  - The in-flight sample is discarded.

## Timing
- Sample accepted at edge E: CLR is visible from E+1.
- Each pair takes PA_LAT+2 cycles.
- out_valid is visible from E + P·(PA_LAT+2). Defaults: E+20.
- Earliest next acceptance is the edge after the out_valid&out_ready edge.
- pa_result is sampled at the single CAP edge only; it is don't-care otherwise.
- Outputs after reset: in_ready=1, out_valid=0, y=0, pa_en=0, pa_clr=0, x1=x2=0, h=0, carry=0.

## Configuration
- FIR_FLUSH_EN defined:
  - Adds input port flush (1 b).
  - flush=1 in IDLE zeroes all d[] at that edge.
  - flush has priority over in_valid: in_ready=0 while flush=1.
  - flush is ignored in other states.
- FIR_FLUSH_EN undefined: no flush port. The delay line clears only on reset.

## Test plan
- Impulse, with defaults and a behavioural pre-adder model: feed 1 then eight 0s, out_ready=1.
  - Required y sequence: 1,2,4,8,8,4,2,1,0.
  - Each out_valid occurs 20 cycles after its acceptance edge.
- Full scale: nine samples of 255, all shifts 3 (COEF_SH=8'hFF).
  - Ninth output y=16320 mod 4096=4032, demonstrating wrap.
- Backpressure: hold out_ready=0 for 10 cycles in DONE with in_valid=1.
  - y stays stable and in_ready=0.
  - Exactly one sample is accepted after the out handshake.
- Reset mid-pair: drive rst=0 during the EN of pair 2.
  - Next cycle: IDLE, pa_en=0, out_valid=0, in_ready=1.
  - Subsequent impulse test passes from scratch.
- Interface check: for each pair assert the following.
  - pa_clr is one cycle.
  - pa_en is exactly 3 consecutive cycles.
  - x1/x2/h/carry are stable across them.
  - x1=d[k] and x2=d[7-k].
- FIR_FLUSH_EN build: load 1,2,3, then flush in IDLE, then feed 0.
  - Required y=0.
  - in_ready=0 during the flush cycle.
